// File: rtl/pred_pkg.sv
// Shared branch-predictor types: ins_type encodings, the orientation-update
// queue entry, and the misprediction test used by the update unit.
package pred_pkg;

    localparam logic [1:0] BR_COND = 2'b00;
    localparam logic [1:0] BR_JUMP = 2'b01;
    localparam logic [1:0] BR_CALL = 2'b10;
    localparam logic [1:0] BR_RET  = 2'b11;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } upd_entry_t;

    // Target only matters when both fetch and EX agree the branch was taken.
    function automatic logic is_mispredict(input logic        pred_taken,
                                           input logic        taken,
                                           input logic [31:0] pred_target,
                                           input logic [31:0] target);
        return (pred_taken != taken) || (pred_taken && taken && (pred_target != target));
    endfunction

endpackage

// File: rtl/pred_upd_fifo.sv
// Orientation-update queue: 2 writes and 1 read per cycle, circular buffer.
// Written entries become visible at the head no earlier than the next cycle.
module pred_upd_fifo
    import pred_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int PW     = $clog2(QDEPTH),
    parameter int CW     = $clog2(QDEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr0_en,
    input  upd_entry_t    wr0_data,
    input  logic          wr1_en,
    input  upd_entry_t    wr1_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output upd_entry_t    head
);

    upd_entry_t    mem [QDEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr_p1;
    logic [1:0]    n_enq;
    upd_entry_t    first_data;

    assign n_enq      = {1'b0, wr0_en} + {1'b0, wr1_en};
    assign wptr_p1    = wptr + PW'(1);
    // A lone lane-1 write still lands in the first free slot.
    assign first_data = wr0_en ? wr0_data : wr1_data;
    assign head       = mem[rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + PW'(n_enq);
            rptr  <= rptr + PW'(pop);
            count <= count + CW'(n_enq) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr0_en || wr1_en) mem[wptr] <= first_data;
            if (wr0_en && wr1_en) mem[wptr_p1] <= wr1_data;
        end
    end

endmodule

// File: rtl/pred_update_unit.sv
// Resolves two EX branch lanes into a one-cycle mispredict report and a queue
// of conditional-branch outcomes. Optional counters behind PRED_UPD_STAT_EN.
module pred_update_unit
    import pred_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex0_valid,
    input  logic [31:0] ex0_pc,
    input  logic [1:0]  ex0_ins_type,
    input  logic        ex0_pred_taken,
    input  logic [31:0] ex0_pred_target,
    input  logic        ex0_taken,
    input  logic [31:0] ex0_target,
    input  logic        ex1_valid,
    input  logic [31:0] ex1_pc,
    input  logic [1:0]  ex1_ins_type,
    input  logic        ex1_pred_taken,
    input  logic [31:0] ex1_pred_target,
    input  logic        ex1_taken,
    input  logic [31:0] ex1_target,
    input  logic        flush,
    output logic        stall,
    output logic        branch_mistaken,
    output logic [31:0] wrong_pc,
    output logic [31:0] right_target,
    output logic [1:0]  ins_type_w,
    output logic        update_orien_en,
    output logic [31:0] retire_pc,
    output logic        right_orien
`ifdef PRED_UPD_STAT_EN
    ,
    output logic [31:0] stat_br_cnt,
    output logic [31:0] stat_mis_cnt
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [CW-1:0] count;
    upd_entry_t    head;
    logic          gate;
    logic          acc0;
    logic          acc1;
    logic          mis0;
    logic          keep1;
    logic          mis1;
    logic          wr0;
    logic          wr1;

    assign stall = count > CW'(QDEPTH - 2);
    assign gate  = !stall && !flush && !branch_mistaken;
    assign acc0  = ex0_valid && gate;
    assign acc1  = ex1_valid && gate;
    assign mis0  = acc0 && is_mispredict(ex0_pred_taken, ex0_taken, ex0_pred_target, ex0_target);
    // An older mispredict squashes the younger lane entirely.
    assign keep1 = acc1 && !mis0;
    assign mis1  = keep1 && is_mispredict(ex1_pred_taken, ex1_taken, ex1_pred_target, ex1_target);
    assign wr0   = acc0 && (ex0_ins_type == BR_COND);
    assign wr1   = keep1 && (ex1_ins_type == BR_COND);

    pred_upd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr0_en   (wr0),
        .wr0_data ('{pc: ex0_pc, taken: ex0_taken}),
        .wr1_en   (wr1),
        .wr1_data ('{pc: ex1_pc, taken: ex1_taken}),
        .pop      (update_orien_en),
        .count    (count),
        .head     (head)
    );

    assign update_orien_en = (count != '0);
    assign retire_pc       = update_orien_en ? head.pc : 32'd0;
    assign right_orien     = update_orien_en && head.taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_mistaken <= 1'b0;
            wrong_pc        <= '0;
            right_target    <= '0;
            ins_type_w      <= '0;
        end else begin
            branch_mistaken <= mis0 || mis1;
            if (mis0) begin
                wrong_pc     <= ex0_pc;
                right_target <= ex0_taken ? ex0_target : ex0_pc + 32'd4;
                ins_type_w   <= ex0_ins_type;
            end else if (mis1) begin
                wrong_pc     <= ex1_pc;
                right_target <= ex1_taken ? ex1_target : ex1_pc + 32'd4;
                ins_type_w   <= ex1_ins_type;
            end
        end
    end

`ifdef PRED_UPD_STAT_EN
    logic [32:0] br_sum;

    assign br_sum = {1'b0, stat_br_cnt} + 33'(wr0) + 33'(wr1);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_br_cnt  <= '0;
            stat_mis_cnt <= '0;
        end else begin
            stat_br_cnt <= br_sum[32] ? '1 : br_sum[31:0];
            if ((mis0 || mis1) && (stat_mis_cnt != '1)) stat_mis_cnt <= stat_mis_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pred_update_unit.sv
// Scoreboard bench for pred_update_unit: a cycle model predicts acceptance,
// queue contents and the mispredict report; the DUT is sampled on negedge.
module tb_pred_update_unit;

    localparam int QDEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex0_valid = 0, ex1_valid = 0;
    logic [31:0] ex0_pc = 0, ex1_pc = 0;
    logic [1:0]  ex0_ins_type = 0, ex1_ins_type = 0;
    logic        ex0_pred_taken = 0, ex1_pred_taken = 0;
    logic [31:0] ex0_pred_target = 0, ex1_pred_target = 0;
    logic        ex0_taken = 0, ex1_taken = 0;
    logic [31:0] ex0_target = 0, ex1_target = 0;
    logic        flush = 0;
    logic        stall, branch_mistaken, update_orien_en, right_orien;
    logic [31:0] wrong_pc, right_target, retire_pc;
    logic [1:0]  ins_type_w;
`ifdef PRED_UPD_STAT_EN
    logic [31:0] stat_br_cnt, stat_mis_cnt;
    logic [31:0] m_br = 0, m_mis = 0;
`endif

    int checks = 0;
    int failures = 0;

    exp_t        sb[$];
    logic        m_bm = 0;
    logic [31:0] m_wrong = 0, m_right = 0;
    logic [1:0]  m_type = 0;
    logic        m_took = 0;

    always #5 clk = ~clk;

    pred_update_unit #(.QDEPTH(QDEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .ex0_valid       (ex0_valid),
        .ex0_pc          (ex0_pc),
        .ex0_ins_type    (ex0_ins_type),
        .ex0_pred_taken  (ex0_pred_taken),
        .ex0_pred_target (ex0_pred_target),
        .ex0_taken       (ex0_taken),
        .ex0_target      (ex0_target),
        .ex1_valid       (ex1_valid),
        .ex1_pc          (ex1_pc),
        .ex1_ins_type    (ex1_ins_type),
        .ex1_pred_taken  (ex1_pred_taken),
        .ex1_pred_target (ex1_pred_target),
        .ex1_taken       (ex1_taken),
        .ex1_target      (ex1_target),
        .flush           (flush),
        .stall           (stall),
        .branch_mistaken (branch_mistaken),
        .wrong_pc        (wrong_pc),
        .right_target    (right_target),
        .ins_type_w      (ins_type_w),
        .update_orien_en (update_orien_en),
        .retire_pc       (retire_pc),
        .right_orien     (right_orien)
`ifdef PRED_UPD_STAT_EN
        ,
        .stat_br_cnt     (stat_br_cnt),
        .stat_mis_cnt    (stat_mis_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic mispred(input logic pt, input logic t,
                                     input logic [31:0] ptgt, input logic [31:0] tgt);
        if (pt != t) return 1'b1;
        return pt && (ptgt != tgt);
    endfunction

    // One clock: compare outputs against the model, then advance the model.
    task automatic step();
        logic m_stall, acc0, acc1, mis0, keep1, mis1;
        @(negedge clk);
        m_stall = sb.size() > QDEPTH - 2;
        check("stall", 32'(stall), 32'(m_stall));
        check("upd_en", 32'(update_orien_en), 32'(sb.size() != 0));
        check("retire_pc", retire_pc, (sb.size() != 0) ? sb[0].pc : 32'd0);
        check("right_orien", 32'(right_orien), (sb.size() != 0) ? 32'(sb[0].taken) : 32'd0);
        check("bm", 32'(branch_mistaken), 32'(m_bm));
        check("wrong_pc", wrong_pc, m_wrong);
        check("right_target", right_target, m_right);
        check("ins_type_w", 32'(ins_type_w), 32'(m_type));
`ifdef PRED_UPD_STAT_EN
        check("stat_br", stat_br_cnt, m_br);
        check("stat_mis", stat_mis_cnt, m_mis);
`endif
        m_took = 0;
        if (reset) begin
            sb.delete();
            m_bm = 0; m_wrong = 0; m_right = 0; m_type = 0;
`ifdef PRED_UPD_STAT_EN
            m_br = 0; m_mis = 0;
`endif
        end else begin
            m_took = !m_stall && !flush && !m_bm;
            acc0  = ex0_valid && m_took;
            acc1  = ex1_valid && m_took;
            mis0  = acc0 && mispred(ex0_pred_taken, ex0_taken, ex0_pred_target, ex0_target);
            keep1 = acc1 && !mis0;
            mis1  = keep1 && mispred(ex1_pred_taken, ex1_taken, ex1_pred_target, ex1_target);
            if (sb.size() != 0) void'(sb.pop_front());
            if (acc0 && ex0_ins_type == 2'b00) begin
                sb.push_back('{pc: ex0_pc, taken: ex0_taken});
`ifdef PRED_UPD_STAT_EN
                m_br++;
`endif
            end
            if (keep1 && ex1_ins_type == 2'b00) begin
                sb.push_back('{pc: ex1_pc, taken: ex1_taken});
`ifdef PRED_UPD_STAT_EN
                m_br++;
`endif
            end
            m_bm = mis0 || mis1;
            if (mis0) begin
                m_wrong = ex0_pc; m_type = ex0_ins_type;
                m_right = ex0_taken ? ex0_target : ex0_pc + 32'd4;
            end else if (mis1) begin
                m_wrong = ex1_pc; m_type = ex1_ins_type;
                m_right = ex1_taken ? ex1_target : ex1_pc + 32'd4;
            end
`ifdef PRED_UPD_STAT_EN
            if (m_bm) m_mis++;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [31:0] pc, input logic [1:0] ty,
                        input logic pt, input logic [31:0] ptgt, input logic t, input logic [31:0] tgt);
        ex0_valid = v; ex0_pc = pc; ex0_ins_type = ty;
        ex0_pred_taken = pt; ex0_pred_target = ptgt; ex0_taken = t; ex0_target = tgt;
    endtask

    task automatic set1(input logic v, input logic [31:0] pc, input logic [1:0] ty,
                        input logic pt, input logic [31:0] ptgt, input logic t, input logic [31:0] tgt);
        ex1_valid = v; ex1_pc = pc; ex1_ins_type = ty;
        ex1_pred_taken = pt; ex1_pred_target = ptgt; ex1_taken = t; ex1_target = tgt;
    endtask

    task automatic idle();
        ex0_valid = 0; ex1_valid = 0; flush = 0;
    endtask

    // Hold the current lanes until the model says they were taken.
    task automatic issue(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!m_took && n < 10);
        if (!m_took) begin
            checks++; failures++;
            $display("FAIL %s: lanes not accepted within %0d cycles", tag, n);
        end
        idle();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || m_bm) && n < 20) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL %s: queue not drained, %0d left", tag, sb.size());
        end
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        step();
        reset = 0;
        step();

        // Single lane-0 mispredict, taken with a new target.
        set0(1, 32'h1c000010, 2'b00, 0, 32'h0, 1, 32'h1c000040);
        issue("mis_taken");
        drain("mis_taken");

        // Lane 0 not-taken mispredict squashes a valid lane 1.
        set0(1, 32'h100, 2'b00, 1, 32'h500, 0, 32'h500);
        set1(1, 32'h180, 2'b00, 0, 32'h0, 0, 32'h0);
        issue("lane0_prio");
        drain("lane0_prio");

        // Return with right direction but wrong target; never queued.
        set0(1, 32'h400, 2'b11, 1, 32'h200, 1, 32'h300);
        issue("ret_target");
        drain("ret_target");

        // Two correct cond branches per cycle, three times, hits stall.
        for (int i = 0; i < 3; i++) begin
            set0(1, 32'h1000 + 32'(i * 16), 2'b00, 1, 32'h2000, 1, 32'h2000);
            set1(1, 32'h1008 + 32'(i * 16), 2'b00, 0, 32'h0, 0, 32'h0);
            issue("burst");
        end
        drain("burst");

        // Correct jump on lane 0, cond mispredict on lane 1 (lone lane-1 write).
        set0(1, 32'h3000, 2'b01, 1, 32'h3100, 1, 32'h3100);
        set1(1, 32'h3004, 2'b00, 0, 32'h0, 1, 32'h3800);
        issue("lane1_mis");
        drain("lane1_mis");

        // Flush with both lanes valid while entries are draining.
        set0(1, 32'h5000, 2'b00, 1, 32'h5100, 1, 32'h5100);
        set1(1, 32'h5004, 2'b00, 0, 32'h0, 0, 32'h0);
        issue("pre_flush");
        set0(1, 32'h6000, 2'b00, 0, 32'h0, 1, 32'h6100);
        set1(1, 32'h6004, 2'b10, 1, 32'h0, 1, 32'h6200);
        flush = 1;
        step();
        step();
        idle();
        drain("flush");

        // Random mix.
        for (int i = 0; i < 60; i++) begin
            set0(1'($urandom_range(0, 1)), 32'h8000 + 32'($urandom_range(0, 255) * 4),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 32'h9000 + 32'($urandom_range(0, 1) * 4), 1'($urandom_range(0, 1)),
                 32'h9000 + 32'($urandom_range(0, 1) * 4));
            set1(1'($urandom_range(0, 1)), 32'ha000 + 32'($urandom_range(0, 255) * 4),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 32'hb000 + 32'($urandom_range(0, 1) * 4), 1'($urandom_range(0, 1)),
                 32'hb000 + 32'($urandom_range(0, 1) * 4));
            flush = ($urandom_range(0, 9) == 0);
            step();
        end
        idle();
        drain("random");

        // Reset with three entries queued.
        set0(1, 32'h7000, 2'b00, 0, 32'h0, 0, 32'h0);
        set1(1, 32'h7004, 2'b00, 0, 32'h0, 0, 32'h0);
        issue("pre_reset_a");
        set0(1, 32'h7010, 2'b00, 0, 32'h0, 0, 32'h0);
        set1(1, 32'h7014, 2'b00, 1, 32'h7100, 0, 32'h0);
        issue("pre_reset_b");
        reset = 1;
        step();
        reset = 0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
